muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same A/B operands as the ALU and the RV32M funct3 from the decoder. It produces a 32-bit result for the writeback mux after a fixed multi-cycle latency. It uses a start/done handshake so the pipeline controller can stall while the unit is busy.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 encodings, FSM states and
// the operand-signedness decode used when a request is accepted.
package muldiv_pkg;

  typedef enum logic [2:0] {
    FNC_MUL    = 3'b000,
    FNC_MULH   = 3'b001,
    FNC_MULHSU = 3'b010,
    FNC_MULHU  = 3'b011,
    FNC_DIV    = 3'b100,
    FNC_DIVU   = 3'b101,
    FNC_REM    = 3'b110,
    FNC_REMU   = 3'b111
  } funct_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  function automatic logic is_div_op(input funct_e f);
    return f[2];
  endfunction

  function automatic logic signed_a(input funct_e f);
    return (f == FNC_MULH) || (f == FNC_MULHSU) || (f == FNC_DIV) || (f == FNC_REM);
  endfunction

  function automatic logic signed_b(input funct_e f);
    return (f == FNC_MULH) || (f == FNC_DIV) || (f == FNC_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: a radix-2 shift-add step or
// one restoring-division step, selected by is_div.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] partial,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] next_partial,
  output logic [W:0]     addsub
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    addsub       = '0;
    next_partial = partial;
    if (is_div) begin
      // Partial is {remainder, dividend}; trial-subtract from the shifted remainder.
      addsub = partial[2*W-1:W-1] - {1'b0, operand};
      if (!addsub[W]) next_partial = {addsub[W-1:0], partial[W-2:0], 1'b1};
      else            next_partial = {partial[2*W-2:0], 1'b0};
    end else begin
      // Partial is {product high, multiplier}; the carry shifts into bit 2W-1.
      addsub       = {1'b0, partial[2*W-1:W]} + (partial[0] ? {1'b0, operand} : '0);
      next_partial = {addsub, partial[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: start/done handshake, one bit per
// cycle over operand magnitudes, sign fix-up on the final iteration.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            start,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN);

  state_e            state;
  funct_e            op;
  logic [CW-1:0]     count;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] partial;

  funct_e            fn_in;
  logic              sa_in, sb_in, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_val;

  logic [2*XLEN-1:0] step_next, prod_fix;
  logic [XLEN:0]     unused_addsub;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_result;

  muldiv_step #(.W(XLEN)) u_step (
    .is_div       (is_div_op(op)),
    .partial      (partial),
    .operand      (operand),
    .next_partial (step_next),
    .addsub       (unused_addsub)
  );

  always_comb begin
    fn_in       = funct_e'(funct);
    sa_in       = signed_a(fn_in) & A[XLEN-1];
    sb_in       = signed_b(fn_in) & B[XLEN-1];
    a_mag       = sa_in ? -A : A;
    b_mag       = sb_in ? -B : B;
    special     = 1'b0;
    special_val = '0;
    if (is_div_op(fn_in)) begin
      if (B == '0) begin
        special     = 1'b1;
        special_val = (fn_in == FNC_DIV || fn_in == FNC_DIVU) ? '1 : A;
      end else if (signed_b(fn_in) && A == {1'b1, {(XLEN-1){1'b0}}} && B == '1) begin
        // Signed overflow: quotient wraps to the dividend, remainder is zero.
        special     = 1'b1;
        special_val = (fn_in == FNC_DIV) ? A : '0;
      end
    end
  end

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -step_next : step_next;
    quot_fix = (sign_a ^ sign_b) ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    rem_fix  = sign_a ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
    case (op)
      FNC_MUL:                     final_result = prod_fix[XLEN-1:0];
      FNC_MULH, FNC_MULHSU,
      FNC_MULHU:                   final_result = prod_fix[2*XLEN-1:XLEN];
      FNC_DIV, FNC_DIVU:           final_result = quot_fix;
      default:                     final_result = rem_fix;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      Result  <= '0;
      count   <= '0;
      op      <= FNC_MUL;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      operand <= '0;
      partial <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          op      <= fn_in;
          sign_a  <= sa_in;
          sign_b  <= sb_in;
          operand <= is_div_op(fn_in) ? b_mag : a_mag;
          partial <= {{XLEN{1'b0}}, (is_div_op(fn_in) ? a_mag : b_mag)};
          count   <= '0;
          ready   <= 1'b0;
          if (special) begin
            Result <= special_val;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          partial <= step_next;
          count   <= count + 1'b1;
          if (count == CW'(XLEN - 1)) begin
            Result <= final_result;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results and
// latencies; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        ready, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .Clock  (clk),
    .Reset  (rst),
    .start  (start),
    .funct  (funct),
    .A      (a),
    .B      (b),
    .ready  (ready),
    .done   (done),
    .Result (result)
  );

  always #5 clk = ~clk;

  // Latency is counted in rising edges after the accepting edge E0:
  // normal ops raise done on E32, special cases on E0 itself.
  typedef struct {
    string       name;
    logic [31:0] exp;
    int          accept;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("done_width", 32'(prev_done), 32'h0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done with result %08h required no done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, result, e.exp);
        check({e.name, "_latency"}, 32'(edge_cnt - e.accept), 32'(e.lat));
      end
    end
    prev_done = done;
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] ux, uy, p;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    r  = '0;
    case (f)
      3'd0: begin p = ux * uy;            r = p[31:0];  end
      3'd1: begin p = sx * sy;            r = p[63:32]; end
      3'd2: begin p = sx * longint'(uy);  r = p[63:32]; end
      3'd3: begin p = ux * uy;            r = p[63:32]; end
      3'd4: if (y == 0) r = '1;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
            else r = 32'($signed(x) / $signed(y));
      3'd5: r = (y == 0) ? '1 : x / y;
      3'd6: if (y == 0) r = x;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = '0;
            else r = 32'($signed(x) % $signed(y));
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && y == 0) return 0;
    if ((f == 3'd4 || f == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 0;
    return 32;
  endfunction

  task automatic wait_ready(output logic ok);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    ok = ready;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 after 200 cycles required ready=1");
    end
  endtask

  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int lat);
    logic ok;
    wait_ready(ok);
    if (ok) begin
      start = 1'b1; funct = f; a = x; b = y;
      @(posedge clk);
      #1;
      sb.push_back('{name, exp, edge_cnt, lat});
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    logic ok;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'h1);
    check("reset_done", 32'(done), 32'h0);
    check("reset_result", result, 32'h0);
    rst = 1'b0;

    issue("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32);
    issue("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
    issue("mulhsu_m1",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
    issue("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32);
    issue("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32);
    issue("divu_100_7", 3'd5, 32'd100,      32'd7,        32'd14,       32);
    issue("remu_100_7", 3'd7, 32'd100,      32'd7,        32'd2,        32);
    issue("divu_by0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
    issue("remu_by0",   3'd7, 32'd5,        32'd0,        32'd5,        0);
    issue("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    issue("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
    drain();

    // MUL with a stray start mid-calculation; ready must stay low throughout CALC.
    issue("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      check("ready_busy", 32'(ready), 32'h0);
      if (i == 10) begin
        start = 1'b1; funct = 3'd5; a = 32'd1234; b = 32'd0;
      end else if (i == 11) begin
        start = 1'b0;
      end
    end
    drain();

    // Reset in the middle of a DIV discards it; no done may follow.
    wait_ready(ok);
    start = 1'b1; funct = 3'd4; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", result, 32'h0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      int          sel;
      f   = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) y = '0;
      else if (sel == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      else if (sel == 2) y = 32'(($urandom_range(1, 9)));
      else if (sel == 3) x = 32'hFFFFFFFF;
      issue("rand", f, x, y, model(f, x, y), model_lat(f, x, y));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
